// File: rtl/rsa_modexp_sequencer_if.sv
// Signal bundle between the modexp sequencer and its surroundings: key load,
// message input stream, result output stream, engine handshake and status.
interface rsa_modexp_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic             key_load;
  logic [31:0]      key_e;
  logic [31:0]      key_n;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready;
  logic             modexp_ready;
  logic [31:0]      modexp_base;
  logic [31:0]      modexp_power;
  logic [31:0]      modexp_e;
  logic [31:0]      modexp_denominator;
  logic             modexp_done;
  logic [31:0]      modexp_result;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] words_done;

  // Sequencer side
  modport master (
    input  key_load, key_e, key_n, in_valid, in_data, out_ready,
           modexp_done, modexp_result,
    output in_ready, out_valid, out_data, modexp_ready, modexp_base,
           modexp_power, modexp_e, modexp_denominator, busy, timeout_err,
           words_done
  );

  // Host / engine side
  modport slave (
    output key_load, key_e, key_n, in_valid, in_data, out_ready,
           modexp_done, modexp_result,
    input  in_ready, out_valid, out_data, modexp_ready, modexp_base,
           modexp_power, modexp_e, modexp_denominator, busy, timeout_err,
           words_done
  );
endinterface

// File: rtl/rsa_modexp_sequencer.sv
// Buffers message words in a small FIFO and walks each one through the modexp
// engine's four-phase ready/done handshake, returning results on a valid/ready stream.
module rsa_modexp_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  rsa_modexp_sequencer_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    RELEASE,
    EMIT
  } state_t;

  state_t           state, state_nxt;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic             full_q;
  logic             push, pop;

  logic [31:0]      key_e_q, key_n_q;
  logic             key_ok, key_take;
  logic [31:0]      power_q, out_data_q;
  logic [TO_W-1:0]  phase_cnt;
  logic             phase_expired;
  logic             issue_timeout, release_timeout;
  logic             drop_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] words_done_q;

  assign key_ok          = key_n_q >= 32'd2;
  assign key_take        = bus.key_load && (state == IDLE);
  assign push            = bus.in_valid && !full_q;
  assign pop             = (state == IDLE) && (state_nxt == LOAD);
  assign phase_expired   = phase_cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign issue_timeout   = (state == ISSUE) && !bus.modexp_done && phase_expired;
  assign release_timeout = (state == RELEASE) && bus.modexp_done && phase_expired;

  // LOAD also waits out a stale done so a request never overlaps the previous done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((count != '0) && key_ok) state_nxt = LOAD;
      LOAD:    if (!bus.modexp_done) state_nxt = ISSUE;
      ISSUE:   if (bus.modexp_done || phase_expired) state_nxt = RELEASE;
      RELEASE: begin
        if (!bus.modexp_done) state_nxt = drop_q ? IDLE : EMIT;
        else if (phase_expired) state_nxt = IDLE;
      end
      EMIT:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop) count_nxt = count + (PTR_W+1)'(1);
    else if (!push && pop) count_nxt = count - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      full_q <= count_nxt == (PTR_W+1)'(FIFO_DEPTH);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_e_q       <= 32'd1;
      key_n_q       <= 32'd0;
      power_q       <= 32'd0;
      out_data_q    <= 32'd0;
      phase_cnt     <= '0;
      drop_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      words_done_q  <= '0;
    end else begin
      if (key_take) begin
        key_e_q <= bus.key_e;
        key_n_q <= bus.key_n;
      end
      if (pop) power_q <= mem[rd_ptr];
      if ((state == ISSUE) && bus.modexp_done) out_data_q <= bus.modexp_result;
      if (state_nxt != state) phase_cnt <= '0;
      else if ((state == ISSUE) || (state == RELEASE)) phase_cnt <= phase_cnt + TO_W'(1);
      // A timed-out word is dropped once the engine side settles.
      if (pop) drop_q <= 1'b0;
      else if (issue_timeout) drop_q <= 1'b1;
      if (key_take) timeout_err_q <= 1'b0;
      else if (issue_timeout || release_timeout) timeout_err_q <= 1'b1;
      if ((state == EMIT) && bus.out_ready) words_done_q <= words_done_q + CNT_W'(1);
    end
  end

  assign bus.in_ready           = !full_q;
  assign bus.out_valid          = state == EMIT;
  assign bus.out_data           = out_data_q;
  assign bus.modexp_ready       = state == ISSUE;
  assign bus.modexp_base        = 32'd1;
  assign bus.modexp_power       = power_q;
  assign bus.modexp_e           = key_e_q;
  assign bus.modexp_denominator = key_n_q;
  assign bus.busy               = (state != IDLE) || (count != '0);
  assign bus.timeout_err        = timeout_err_q;
  assign bus.words_done         = words_done_q;

endmodule
